// File: rtl/cache_port_arbiter_if.sv
// Requester, cache and status signals of cache_port_arbiter.
// The arbiter uses the slave modport; the environment uses master.
interface cache_port_arbiter_if #(
    parameter int BW_DATA        = 32,
    parameter int BW_ADDR        = 32,
    parameter int TAG_DEPTH_LOG2 = 3
);
    logic [1:0]                req_request_i;
    logic [1:0]                req_wren_i;
    logic [2*BW_ADDR-1:0]      req_addr_i;
    logic [2*BW_DATA-1:0]      req_data_i;
    logic [1:0]                req_grant_o;
    logic [1:0]                req_valid_o;
    logic [BW_DATA-1:0]        rsp_data_o;
    logic                      cache_request_o;
    logic                      cache_wren_o;
    logic [BW_ADDR-1:0]        cache_addr_o;
    logic [BW_DATA-1:0]        cache_data_o;
    logic                      cache_stall_i;
    logic                      cache_valid_i;
    logic [BW_DATA-1:0]        cache_data_i;
    logic [TAG_DEPTH_LOG2:0]   outstanding_o;
    logic                      error_o;

    modport slave (
        input  req_request_i, req_wren_i, req_addr_i, req_data_i,
        input  cache_stall_i, cache_valid_i, cache_data_i,
        output req_grant_o, req_valid_o, rsp_data_o,
        output cache_request_o, cache_wren_o, cache_addr_o, cache_data_o,
        output outstanding_o, error_o
    );

    modport master (
        output req_request_i, req_wren_i, req_addr_i, req_data_i,
        output cache_stall_i, cache_valid_i, cache_data_i,
        input  req_grant_o, req_valid_o, rsp_data_o,
        input  cache_request_o, cache_wren_o, cache_addr_o, cache_data_o,
        input  outstanding_o, error_o
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-requester arbiter onto the cache port with an in-order read-tag FIFO; round-robin if CACHE_ARB_ROUND_ROBIN_EN, else fixed priority.
// Latency: grant combinational, cache request next cycle, return one cycle after cache_valid_i; no grant on stall, reads held off while tag FIFO full.
module cache_port_arbiter #(
    parameter int BW_DATA        = 32,
    parameter int BW_ADDR        = 32,
    parameter int TAG_DEPTH_LOG2 = 3
) (
    input logic                  clock_control_i,
    input logic                  reset_i,
    cache_port_arbiter_if.slave  bus
);
    localparam int DEPTH = 1 << TAG_DEPTH_LOG2;
    localparam logic [TAG_DEPTH_LOG2:0] FULL_CNT = (TAG_DEPTH_LOG2+1)'(DEPTH);

    logic [TAG_DEPTH_LOG2:0]   count;
    logic [TAG_DEPTH_LOG2-1:0] wr_ptr;
    logic [TAG_DEPTH_LOG2-1:0] rd_ptr;
    logic                      tag_mem [DEPTH];
    logic                      tag_full;
    logic                      tag_empty;
    logic [1:0]                elig;
    logic [1:0]                grant;
    logic                      winner;
    logic                      win_wren;
    logic [BW_ADDR-1:0]        win_addr;
    logic [BW_DATA-1:0]        win_data;
    logic                      push;
    logic                      pop;

    // Eligibility uses the registered count, so a same-cycle pop never frees a slot early.
    assign tag_full  = (count == FULL_CNT);
    assign tag_empty = (count == '0);
    assign elig = bus.req_request_i & {2{~bus.cache_stall_i & ~reset_i}}
                & (bus.req_wren_i | {2{~tag_full}});

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last;

    assign winner = (elig == 2'b11) ? ~last : elig[1];

    always_ff @(posedge clock_control_i) begin
        if (reset_i) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= winner;
        end
    end
`else
    assign winner = ~elig[0];
`endif

    assign grant    = (|elig) ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign win_wren = winner ? bus.req_wren_i[1] : bus.req_wren_i[0];
    assign win_addr = winner ? bus.req_addr_i[2*BW_ADDR-1:BW_ADDR] : bus.req_addr_i[BW_ADDR-1:0];
    assign win_data = winner ? bus.req_data_i[2*BW_DATA-1:BW_DATA] : bus.req_data_i[BW_DATA-1:0];
    assign push     = (|grant) & ~win_wren;
    assign pop      = bus.cache_valid_i & ~tag_empty;

    assign bus.req_grant_o   = grant;
    assign bus.outstanding_o = count;

    always_ff @(posedge clock_control_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clock_control_i) begin
        if (reset_i) begin
            bus.cache_request_o <= 1'b0;
            bus.cache_wren_o    <= 1'b0;
            bus.cache_addr_o    <= '0;
            bus.cache_data_o    <= '0;
            bus.req_valid_o     <= 2'b00;
            bus.rsp_data_o      <= '0;
            bus.error_o         <= 1'b0;
            count               <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
        end else begin
            bus.cache_request_o <= |grant;
            if (|grant) begin
                bus.cache_wren_o <= win_wren;
                bus.cache_addr_o <= win_addr;
                bus.cache_data_o <= win_data;
            end
            bus.req_valid_o <= pop ? (tag_mem[rd_ptr] ? 2'b10 : 2'b01) : 2'b00;
            if (pop) begin
                bus.rsp_data_o <= bus.cache_data_i;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (bus.cache_valid_i && tag_empty) begin
                bus.error_o <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: stimulus queues expected cache issues and read returns, a negedge monitor pops and compares them.
module tb_cache_port_arbiter;
    localparam int BW_DATA = 32;
    localparam int BW_ADDR = 32;
    localparam int TDL     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .TAG_DEPTH_LOG2(TDL)) bus ();

    cache_port_arbiter #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .TAG_DEPTH_LOG2(TDL)) dut (
        .clock_control_i (clk),
        .reset_i         (rst),
        .bus             (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [64:0] exp_issue [$];
    logic [33:0] exp_rsp   [$];

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [64:0] ent(input logic w, input logic [31:0] a, input logic [31:0] d);
        return {w, a, d};
    endfunction

    // Monitor: every cache issue and every read return must match the head of its queue.
    always @(negedge clk) begin
        if (bus.cache_request_o) begin
            if (exp_issue.size() == 0) begin
                total++; bad++;
                $display("FAIL issue_unexpected: got %0h want none",
                         {bus.cache_wren_o, bus.cache_addr_o, bus.cache_data_o});
            end else begin
                chk("issue", 128'({bus.cache_wren_o, bus.cache_addr_o, bus.cache_data_o}),
                    128'(exp_issue.pop_front()));
            end
        end
        if (bus.req_valid_o != 2'b00) begin
            if (exp_rsp.size() == 0) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: got %0h want none", {bus.req_valid_o, bus.rsp_data_o});
            end else begin
                chk("rsp", 128'({bus.req_valid_o, bus.rsp_data_o}), 128'(exp_rsp.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_request_i = 2'b00;
        bus.req_wren_i    = 2'b00;
        bus.cache_stall_i = 1'b0;
        bus.cache_valid_i = 1'b0;
        bus.cache_data_i  = '0;
    endtask

    task automatic drive_req(input int r, input logic wren, input logic [31:0] addr, input logic [31:0] data);
        bus.req_request_i[r]              = 1'b1;
        bus.req_wren_i[r]                 = wren;
        bus.req_addr_i[r*BW_ADDR +: BW_ADDR] = addr;
        bus.req_data_i[r*BW_DATA +: BW_DATA] = data;
    endtask

    task automatic ret(input logic [31:0] data, input int r);
        bus.cache_valid_i = 1'b1;
        bus.cache_data_i  = data;
        exp_rsp.push_back({oh(r), data});
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("issue_queue_drained", 128'(exp_issue.size()), 128'(0));
        chk("rsp_queue_drained", 128'(exp_rsp.size()), 128'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int order [$];
        idle_inputs();
        bus.req_addr_i = '0;
        bus.req_data_i = '0;
        rst = 1'b1;
        bus.req_request_i = 2'b11;
        cyc();
        @(negedge clk);
        chk("reset_grant", 128'(bus.req_grant_o), 128'(0));
        chk("reset_cache_req", 128'(bus.cache_request_o), 128'(0));
        chk("reset_addr", 128'(bus.cache_addr_o), 128'(0));
        chk("reset_valid", 128'(bus.req_valid_o), 128'(0));
        chk("reset_rsp", 128'(bus.rsp_data_o), 128'(0));
        chk("reset_outstanding", 128'(bus.outstanding_o), 128'(0));
        chk("reset_error", 128'(bus.error_o), 128'(0));
        do_reset();

        // Single read from requester 0, returned two cycles after the grant.
        drive_req(0, 1'b0, 32'h10, 32'h0);
        exp_issue.push_back(ent(1'b0, 32'h10, 32'h0));
        @(negedge clk);
        chk("single_grant", 128'(bus.req_grant_o), 128'(2'b01));
        cyc();
        idle_inputs();
        chk("single_outstanding1", 128'(bus.outstanding_o), 128'(1));
        cyc();
        chk("single_req_drop", 128'(bus.cache_request_o), 128'(0));
        ret(32'hDEADBEEF, 0);
        cyc();
        idle_inputs();
        chk("single_outstanding0", 128'(bus.outstanding_o), 128'(0));
        cyc();

        // Both requesters read continuously.
        do_reset();
        drive_req(0, 1'b0, 32'h100, 32'h11111111);
        drive_req(1, 1'b0, 32'h200, 32'h22222222);
        for (int i = 0; i < 6; i++) begin
            int w;
            w = RR ? (i % 2) : 0;
            order.push_back(w);
            exp_issue.push_back(w == 1 ? ent(1'b0, 32'h200, 32'h22222222) : ent(1'b0, 32'h100, 32'h11111111));
            @(negedge clk);
            chk("cont_grant", 128'(bus.req_grant_o), 128'(oh(w)));
            cyc();
        end
        idle_inputs();
        chk("cont_outstanding6", 128'(bus.outstanding_o), 128'(6));
        for (int k = 0; k < 6; k++) begin
            ret(32'hA000 + k, order[k]);
            cyc();
        end
        idle_inputs();
        chk("cont_outstanding0", 128'(bus.outstanding_o), 128'(0));
        cyc();

        // Stall for five cycles while both request.
        do_reset();
        drive_req(0, 1'b0, 32'h500, 32'h0);
        drive_req(1, 1'b0, 32'h600, 32'h0);
        exp_issue.push_back(ent(1'b0, 32'h500, 32'h0));
        @(negedge clk);
        chk("stall_pre_grant", 128'(bus.req_grant_o), 128'(2'b01));
        cyc();
        bus.cache_stall_i = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_grant", 128'(bus.req_grant_o), 128'(0));
            if (s >= 1) chk("stall_cache_req", 128'(bus.cache_request_o), 128'(0));
            cyc();
        end
        bus.cache_stall_i = 1'b0;
        exp_issue.push_back(RR ? ent(1'b0, 32'h600, 32'h0) : ent(1'b0, 32'h500, 32'h0));
        @(negedge clk);
        chk("stall_release_grant", 128'(bus.req_grant_o), 128'(oh(RR ? 1 : 0)));
        cyc();
        idle_inputs();
        chk("stall_outstanding", 128'(bus.outstanding_o), 128'(2));
        cyc();

        // Fill the tag FIFO, then write while full and refill after one return.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_req(0, 1'b0, 32'h300 + 4*i, 32'h0);
            exp_issue.push_back(ent(1'b0, 32'h300 + 4*i, 32'h0));
            @(negedge clk);
            chk("fill_grant", 128'(bus.req_grant_o), 128'(2'b01));
            cyc();
        end
        chk("full_outstanding", 128'(bus.outstanding_o), 128'(8));
        drive_req(0, 1'b0, 32'h380, 32'h0);
        drive_req(1, 1'b1, 32'h400, 32'hCAFEF00D);
        exp_issue.push_back(ent(1'b1, 32'h400, 32'hCAFEF00D));
        @(negedge clk);
        chk("write_when_full", 128'(bus.req_grant_o), 128'(2'b10));
        cyc();
        bus.req_request_i[1] = 1'b0;
        @(negedge clk);
        chk("read_blocked_full", 128'(bus.req_grant_o), 128'(0));
        chk("full_outstanding_write", 128'(bus.outstanding_o), 128'(8));
        cyc();
        ret(32'hB0, 0);
        @(negedge clk);
        chk("full_with_pop", 128'(bus.req_grant_o), 128'(0));
        cyc();
        bus.cache_valid_i = 1'b0;
        exp_issue.push_back(ent(1'b0, 32'h380, 32'h0));
        @(negedge clk);
        chk("read_after_pop", 128'(bus.req_grant_o), 128'(2'b01));
        cyc();
        @(negedge clk);
        chk("refull_block", 128'(bus.req_grant_o), 128'(0));
        chk("refull_outstanding", 128'(bus.outstanding_o), 128'(8));
        cyc();
        idle_inputs();
        cyc();

        // Twenty alternating reads, each returned three cycles after its grant.
        do_reset();
        for (int c = 0; c < 23; c++) begin
            bus.req_request_i = 2'b00;
            bus.cache_valid_i = 1'b0;
            if (c < 20) begin
                drive_req(c % 2, 1'b0, 32'h1000 + 16*c, 32'h5500 + c);
                exp_issue.push_back(ent(1'b0, 32'h1000 + 16*c, 32'h5500 + c));
            end
            if (c >= 3) ret(32'hD0000000 + (c - 3), (c - 3) % 2);
            if (c == 10) chk("wrap_outstanding3", 128'(bus.outstanding_o), 128'(3));
            if (c < 20) begin
                @(negedge clk);
                chk("wrap_grant", 128'(bus.req_grant_o), 128'(oh(c % 2)));
            end
            cyc();
        end
        idle_inputs();
        chk("wrap_outstanding0", 128'(bus.outstanding_o), 128'(0));
        cyc();

        // Return with an empty FIFO, then reset with reads outstanding.
        do_reset();
        bus.cache_valid_i = 1'b1;
        bus.cache_data_i  = 32'h99;
        cyc();
        bus.cache_valid_i = 1'b0;
        chk("empty_error", 128'(bus.error_o), 128'(1));
        chk("empty_no_valid", 128'(bus.req_valid_o), 128'(0));
        cyc();
        cyc();
        chk("error_sticky", 128'(bus.error_o), 128'(1));
        chk("error_outstanding", 128'(bus.outstanding_o), 128'(0));
        do_reset();
        chk("error_cleared", 128'(bus.error_o), 128'(0));
        for (int i = 0; i < 3; i++) begin
            drive_req(0, 1'b0, 32'h700 + 4*i, 32'h0);
            exp_issue.push_back(ent(1'b0, 32'h700 + 4*i, 32'h0));
            @(negedge clk);
            chk("pre_reset_grant", 128'(bus.req_grant_o), 128'(2'b01));
            cyc();
        end
        idle_inputs();
        chk("pre_reset_outstanding", 128'(bus.outstanding_o), 128'(3));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("post_reset_outstanding", 128'(bus.outstanding_o), 128'(0));
        chk("post_reset_error", 128'(bus.error_o), 128'(0));
        bus.cache_valid_i = 1'b1;
        bus.cache_data_i  = 32'h77;
        cyc();
        bus.cache_valid_i = 1'b0;
        chk("late_return_error", 128'(bus.error_o), 128'(1));
        chk("late_return_no_valid", 128'(bus.req_valid_o), 128'(0));
        cyc();
        chk("final_issue_queue", 128'(exp_issue.size()), 128'(0));
        chk("final_rsp_queue", 128'(exp_rsp.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester front end for the cache top-level core port, in the core/cache clock domain. Accepts read/write requests from two requesters (e.g. instruction and data sides), issues at most one per cycle to the cache and honours the cache stall. Keeps an in-order tag FIFO of outstanding reads so each `core_valid` response returns to the requester that issued it.

## Interface
- `BW_DATA`, 32, data word width (matches `TOP_BW_DATA_WORD`)
- `BW_ADDR`, 32, byte-address width
- `TAG_DEPTH_LOG2`, 3, log2 of outstanding-read tag FIFO depth (8 entries)

Ports (clock domain: `clock_control_i`):
- `clock_control_i`  in  1  core/cache clock, all logic on posedge
- `reset_i`  in  1  synchronous, active-high reset
- `req_request_i`  in  2  per-requester request, bit r = requester r, held until granted
- `req_wren_i`  in  2  per-requester write enable (1 = write)
- `req_addr_i`  in  2*BW_ADDR  per-requester byte address, requester r at [r*BW_ADDR +: BW_ADDR]
- `req_data_i`  in  2*BW_DATA  per-requester write data, same packing
- `req_grant_o`  out  2  combinational one-hot accept strobe
- `req_valid_o`  out  2  registered read-return strobe, one-hot
- `rsp_data_o`  out  BW_DATA  read data, shared, qualified by `req_valid_o`
- `cache_request_o`  out  1  request to cache
- `cache_wren_o`  out  1  write enable to cache
- `cache_addr_o`  out  BW_ADDR  address to cache
- `cache_data_o`  out  BW_DATA  write data to cache
- `cache_stall_i`  in  1  cache stall
- `cache_valid_i`  in  1  cache read-return valid
- `cache_data_i`  in  BW_DATA  cache read data
- `outstanding_o`  out  TAG_DEPTH_LOG2+1  number of reads issued but not yet returned
- `error_o`  out  1  sticky protocol error

## Operation
- Eligibility of requester r: `req_request_i[r]` high, `cache_stall_i` low, and, if a read, tag FIFO not full. Writes stay eligible when the FIFO is full.
- Winner is chosen from the eligible set (see Configuration). `req_grant_o[winner]` is high in the same cycle. No grant is given while `cache_stall_i` is high.
- On a grant edge: `cache_request_o`←1, and `cache_wren_o`/`cache_addr_o`/`cache_data_o` load the winner's fields. If the grant is a read, the winner ID is pushed into the tag FIFO.
- On an edge with no grant: `cache_request_o`←0. Address, data and wren hold their last values.
- On `cache_valid_i`: pop the head tag; `req_valid_o[tag]`←1 and `rsp_data_o`←`cache_data_i` on that edge.
- Push and pop in the same cycle: both take effect and the count is unchanged. Full with a simultaneous pop still blocks reads that cycle, because eligibility uses the registered count.
- `cache_valid_i` with an empty FIFO: `error_o`←1, no `req_valid_o`, pointers unchanged. `error_o` clears only on reset.
- Pointers are TAG_DEPTH_LOG2 bits and wrap modulo the depth. `outstanding_o` = registered count, range 0..depth.

## Timing
- Reset (synchronous, `reset_i`=1 at posedge) sets `cache_request_o`, `cache_wren_o`, `cache_addr_o`, `cache_data_o`, `req_valid_o`, `rsp_data_o`, `outstanding_o`, `error_o` and the FIFO pointers to 0. The round-robin pointer is set to "requester 1 last".
- While `reset_i` is high, `req_grant_o` = 0.
- Reset mid-operation discards all outstanding tags. Any later `cache_valid_i` raises `error_o`.
- Grant in cycle N → `cache_request_o` high in cycle N+1. One request per granted cycle, so back-to-back grants give a continuous `cache_request_o`.
- `cache_valid_i` in cycle M → `req_valid_o`/`rsp_data_o` in cycle M+1, one cycle per return.
- A requester must hold its fields stable while `req_request_i` is high and ungranted. It deasserts or presents a new request after the grant cycle.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - When both requesters are eligible, the one not granted last wins.
  - The last-grant pointer updates only on a grant.
- `CACHE_ARB_ROUND_ROBIN_EN` undefined: fixed priority, requester 0 always wins when eligible. No last-grant pointer is built.

## Test plan
- Single read, requester 0, addr 0x10, cache returns 0xDEADBEEF two cycles later → grant cycle N, `cache_request_o` at N+1 with addr 0x10/wren 0, `req_valid_o`=2'b01 and `rsp_data_o`=0xDEADBEEF one cycle after `cache_valid_i`, `outstanding_o` 1→0.
- Both requesters read continuously with cache never stalling:
  - round-robin build: grants alternate 01,10,01,10…
  - fixed build: requester 0 is granted every cycle.
  - Returns route in issue order.
- `cache_stall_i` high 5 cycles while both request → `req_grant_o`=0 and `cache_request_o`=0 from the next edge. The first grant occurs in the first cycle stall is low.
- Eight reads with no returns → `outstanding_o`=8, further reads not granted, a pending write still granted. One return is followed by exactly one read grant.
- Interleaved returns after pointer wrap (20 reads alternating requesters, returns delayed 3 cycles) → every `req_valid_o` hits the issuing requester and data matches the scoreboard.
- `cache_valid_i` with FIFO empty → `error_o`=1 and held. Reset with 3 reads outstanding → `outstanding_o`=0; a late `cache_valid_i` sets `error_o`.
